// File: rtl/md_pkg.sv
// Shared types and constants for the cartridge bus sequencer.
// Imported by the top and the read cache.
package md_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        WR_REQ,
        HOLD,
        WAIT_REL
    } state_t;

    // Word offset of byte A130F1 inside the cart_time space
    localparam logic [6:0]  MAP_REG_OFS     = 7'h78;
    localparam logic [15:0] RD_TIMEOUT_DATA = 16'hFFFF;

endpackage

// File: rtl/md_cart_rdcache.sv
// Single-entry read cache keyed by the memory word address.
// Invalidate wins over a fill issued in the same cycle.
module md_cart_rdcache
    import md_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [22:0] lookup_tag,
    output logic        hit,
    output logic [15:0] hit_data,
    input  logic        fill,
    input  logic [22:0] fill_tag,
    input  logic [15:0] fill_data,
    input  logic        inval
);

    logic        valid;
    logic [22:0] tag;
    logic [15:0] data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else if (inval) begin
            valid <= 1'b0;
        end else if (fill) begin
            valid <= 1'b1;
            tag   <= fill_tag;
            data  <= fill_data;
        end
    end

    always_comb begin
        hit      = valid && (tag == lookup_tag);
        hit_data = data;
    end

endmodule

// File: rtl/md_cart_ctrl.sv
// Cartridge bus to word-memory sequencer with read cache,
// SRAM write window, A130xx SRAM-enable register and timeout.
module md_cart_ctrl
    import md_pkg::*;
#(
    parameter int          ROM_AW    = 22,
    parameter logic [22:0] SRAM_BASE = 23'h100000,
    parameter int          SRAM_AW   = 14,
    parameter int          TIMEOUT   = 24
) (
    input  logic        MCLK2,
    input  logic        SRES,
    input  logic [22:0] cart_address,
    input  logic        cart_cs,
    input  logic        cart_oe,
    input  logic        cart_lwr,
    input  logic        cart_uwr,
    input  logic        cart_time,
    input  logic [15:0] cart_data_wr,
    output logic [15:0] cart_data,
    output logic        cart_data_en,
    output logic        mem_req,
    output logic        mem_we,
    output logic [1:0]  mem_be,
    output logic [22:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        sram_en,
    output logic        late_err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT - 1);
    localparam logic [23:0]   SRAM_END  = {1'b0, SRAM_BASE} + 24'(1 << SRAM_AW);
    localparam logic [21:0]   SRAM_MASK = 22'((1 << SRAM_AW) - 1);
    localparam logic [21:0]   ROM_MASK  = 22'((64'(1) << ROM_AW) - 64'(1));

    state_t        state;
    logic          strobe, strobe_q;
    logic          map_wr, map_q;
    logic          start, rd_start, wr_start, map_start;
    logic          sram_hit, rel_q;
    logic [22:0]   tgt_addr;
    logic [CW-1:0] cnt;
    logic          req_done;
    logic [15:0]   rd_value;
    logic          cache_hit, cache_fill, cache_inval;
    logic [15:0]   cache_data;

    always_comb begin
        strobe    = cart_cs & (cart_oe | cart_lwr | cart_uwr);
        start     = strobe & ~strobe_q & ~cart_time;
        rd_start  = start & cart_oe;
        wr_start  = start & ~cart_oe;
        map_wr    = cart_time & cart_lwr;
        map_start = map_wr & ~map_q & (cart_address[6:0] == MAP_REG_OFS);
        sram_hit  = sram_en
                  && ({1'b0, cart_address} >= {1'b0, SRAM_BASE})
                  && ({1'b0, cart_address} < SRAM_END);
        // Bit 22 of the memory address selects the SRAM region
        tgt_addr  = sram_hit ? {1'b1, cart_address[21:0] & SRAM_MASK}
                             : {1'b0, cart_address[21:0] & ROM_MASK};
        req_done  = mem_ack | (cnt == CNT_LAST);
        rd_value  = mem_ack ? mem_rdata : RD_TIMEOUT_DATA;
        cache_fill  = (state == RD_REQ) & mem_ack;
        cache_inval = map_start | ((state == IDLE) & wr_start);
    end

    md_cart_rdcache u_cache (
        .clk        (MCLK2),
        .rst_n      (SRES),
        .lookup_tag (tgt_addr),
        .hit        (cache_hit),
        .hit_data   (cache_data),
        .fill       (cache_fill),
        .fill_tag   (mem_addr),
        .fill_data  (mem_rdata),
        .inval      (cache_inval)
    );

    always_ff @(posedge MCLK2 or negedge SRES) begin
        if (!SRES) begin
            state        <= IDLE;
            strobe_q     <= 1'b0;
            map_q        <= 1'b0;
            rel_q        <= 1'b0;
            cnt          <= '0;
            cart_data    <= '0;
            cart_data_en <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_be       <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            sram_en      <= 1'b0;
            late_err     <= 1'b0;
        end else begin
            strobe_q <= strobe;
            map_q    <= map_wr;
            if (map_start) sram_en <= cart_data_wr[0];

            unique case (state)
                IDLE: begin
                    if (rd_start && cache_hit) begin
                        cart_data    <= cache_data;
                        cart_data_en <= 1'b1;
                        state        <= HOLD;
                    end else if (rd_start) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_be   <= 2'b11;
                        mem_addr <= tgt_addr;
                        cnt      <= '0;
                        rel_q    <= 1'b0;
                        state    <= RD_REQ;
                    end else if (wr_start && sram_hit) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_be    <= {cart_uwr, cart_lwr};
                        mem_addr  <= tgt_addr;
                        mem_wdata <= cart_data_wr;
                        cnt       <= '0;
                        state     <= WR_REQ;
                    end else if (wr_start) begin
                        state <= WAIT_REL;
                    end
                end
                RD_REQ: begin
                    if (!strobe) rel_q <= 1'b1;
                    if (req_done) begin
                        mem_req <= 1'b0;
                        if (!mem_ack) late_err <= 1'b1;
                        // A reader that let go still completes, but gets no data
                        if (rel_q || !strobe) begin
                            state <= IDLE;
                        end else begin
                            cart_data    <= rd_value;
                            cart_data_en <= 1'b1;
                            state        <= HOLD;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WR_REQ: begin
                    if (req_done) begin
                        mem_req <= 1'b0;
                        if (!mem_ack) late_err <= 1'b1;
                        state <= WAIT_REL;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (!strobe) begin
                        cart_data_en <= 1'b0;
                        state        <= IDLE;
                    end
                end
                WAIT_REL: begin
                    if (!strobe) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_cart_ctrl.sv
// Bench for md_cart_ctrl: transaction-level model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_md_cart_ctrl;

    logic        MCLK2 = 1'b0;
    logic        SRES = 1'b0;
    logic [22:0] cart_address = '0;
    logic        cart_cs = 1'b0;
    logic        cart_oe = 1'b0;
    logic        cart_lwr = 1'b0;
    logic        cart_uwr = 1'b0;
    logic        cart_time = 1'b0;
    logic [15:0] cart_data_wr = '0;
    logic [15:0] cart_data;
    logic        cart_data_en;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_be;
    logic [22:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic        sram_en;
    logic        late_err;

    int n_pass = 0;
    int n_total = 0;

    always #5 MCLK2 = ~MCLK2;

    md_cart_ctrl dut (
        .MCLK2        (MCLK2),
        .SRES         (SRES),
        .cart_address (cart_address),
        .cart_cs      (cart_cs),
        .cart_oe      (cart_oe),
        .cart_lwr     (cart_lwr),
        .cart_uwr     (cart_uwr),
        .cart_time    (cart_time),
        .cart_data_wr (cart_data_wr),
        .cart_data    (cart_data),
        .cart_data_en (cart_data_en),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_be       (mem_be),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .sram_en      (sram_en),
        .late_err     (late_err)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h expected=%h t=%0t",
                      name, act, exp, $time);
    endtask

    // Transaction-level model: one outstanding memory request at most
    logic        m_sq, m_mq, m_req, m_rd, m_aban, m_drive, m_wait;
    logic        c_valid;
    logic [22:0] c_tag, tgt;
    logic [15:0] c_data;
    int          m_age;
    logic        e_req, e_en, e_we, e_sram, e_late;
    logic [1:0]  e_be;
    logic [22:0] e_addr;
    logic [15:0] e_data, e_wdata;
    logic        strb, st, inr;

    always @(posedge MCLK2 or negedge SRES) begin
        if (!SRES) begin
            m_sq = 0; m_mq = 0; m_req = 0; m_rd = 0; m_aban = 0;
            m_drive = 0; m_wait = 0; c_valid = 0; m_age = 0;
            e_req = 0; e_en = 0; e_we = 0; e_sram = 0; e_late = 0;
            e_be = 0; e_addr = 0; e_data = 0; e_wdata = 0;
        end else begin
            strb = cart_cs & (cart_oe | cart_lwr | cart_uwr);
            st   = strb & !m_sq & !cart_time;
            inr  = e_sram && cart_address >= 23'h100000
                          && cart_address < 23'h104000;
            tgt  = inr ? (23'h400000 | (cart_address & 23'h003FFF))
                       : (cart_address & 23'h3FFFFF);
            if (m_req) begin
                if (!strb) m_aban = 1;
                m_age++;
                if (mem_ack || m_age == 24) begin
                    m_req = 0;
                    e_req = 0;
                    if (!mem_ack) e_late = 1;
                    else if (m_rd) begin
                        c_valid = 1; c_tag = e_addr; c_data = mem_rdata;
                    end
                    if (!m_rd) m_wait = 1;
                    else if (!m_aban) begin
                        m_drive = 1;
                        e_en = 1;
                        e_data = mem_ack ? mem_rdata : 16'hFFFF;
                    end
                end
            end else if (m_drive) begin
                if (!strb) begin m_drive = 0; e_en = 0; end
            end else if (m_wait) begin
                if (!strb) m_wait = 0;
            end else if (st && cart_oe) begin
                if (c_valid && c_tag == tgt) begin
                    m_drive = 1; e_en = 1; e_data = c_data;
                end else begin
                    m_req = 1; m_rd = 1; m_age = 0; m_aban = 0;
                    e_req = 1; e_addr = tgt; e_we = 0; e_be = 2'b11;
                end
            end else if (st) begin
                c_valid = 0;
                if (inr) begin
                    m_req = 1; m_rd = 0; m_age = 0;
                    e_req = 1; e_addr = tgt; e_we = 1;
                    e_be = {cart_uwr, cart_lwr}; e_wdata = cart_data_wr;
                end else begin
                    m_wait = 1;
                end
            end
            if (cart_time && cart_lwr && !m_mq
                && cart_address[6:0] == 7'h78) begin
                e_sram = cart_data_wr[0];
                c_valid = 0;
            end
            m_sq = strb;
            m_mq = cart_time & cart_lwr;
        end
    end

    always @(negedge MCLK2) begin
        chk("req", 32'(mem_req), 32'(e_req));
        chk("data_en", 32'(cart_data_en), 32'(e_en));
        chk("sram_en", 32'(sram_en), 32'(e_sram));
        chk("late_err", 32'(late_err), 32'(e_late));
        if (e_req) begin
            chk("mem_addr", 32'(mem_addr), 32'(e_addr));
            chk("mem_we", 32'(mem_we), 32'(e_we));
            chk("mem_be", 32'(mem_be), 32'(e_be));
            if (e_we) chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
        end
        if (e_en) chk("cart_data", 32'(cart_data), 32'(e_data));
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge MCLK2);
            #2;
        end
    endtask

    task automatic wait_req();
        bit got;
        got = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (mem_req) begin
                got = 1;
                break;
            end
        end
        chk("req_seen", 32'(got), 32'd1);
    endtask

    task automatic ack(input logic [15:0] d);
        mem_ack = 1'b1;
        mem_rdata = d;
        tick(1);
        mem_ack = 1'b0;
    endtask

    task automatic release_bus();
        cart_cs = 0; cart_oe = 0; cart_lwr = 0; cart_uwr = 0;
        cart_time = 0;
    endtask

    initial begin
        int n;
        tick(3);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_en", 32'(cart_data_en), 32'd0);
        chk("rst_data", 32'(cart_data), 32'd0);
        SRES = 1'b1;
        tick(2);

        // Plain ROM read, ack five cycles after the request
        cart_address = 23'h000100; cart_cs = 1; cart_oe = 1;
        wait_req();
        chk("t1_addr", 32'(mem_addr), 32'h000100);
        chk("t1_we", 32'(mem_we), 32'd0);
        tick(4);
        ack(16'h4E71);
        chk("t1_en", 32'(cart_data_en), 32'd1);
        chk("t1_data", 32'(cart_data), 32'h4E71);
        chk("t1_req_drop", 32'(mem_req), 32'd0);
        tick(2);
        release_bus();
        tick(1);
        chk("t1_en_off", 32'(cart_data_en), 32'd0);
        tick(2);

        // Same address again is served from the cache
        cart_address = 23'h000100; cart_cs = 1; cart_oe = 1;
        tick(1);
        chk("t2_en", 32'(cart_data_en), 32'd1);
        chk("t2_data", 32'(cart_data), 32'h4E71);
        chk("t2_noreq", 32'(mem_req), 32'd0);
        tick(3);
        release_bus();
        tick(2);

        // SRAM write while disabled, enable via A130F1, write again
        cart_address = 23'h100004; cart_cs = 1; cart_lwr = 1;
        cart_data_wr = 16'h00AA;
        tick(1);
        chk("t3_drop", 32'(mem_req), 32'd0);
        tick(2);
        release_bus();
        tick(2);
        cart_address = 23'h000078; cart_time = 1; cart_lwr = 1;
        cart_data_wr = 16'h0001;
        tick(1);
        chk("t3_sram_en", 32'(sram_en), 32'd1);
        release_bus();
        tick(2);
        cart_address = 23'h100004; cart_cs = 1; cart_lwr = 1;
        cart_data_wr = 16'h00AA;
        wait_req();
        chk("t3_we", 32'(mem_we), 32'd1);
        chk("t3_be", 32'(mem_be), 32'd1);
        chk("t3_addr", 32'(mem_addr), 32'h400004);
        chk("t3_wdata", 32'(mem_wdata), 32'h00AA);
        tick(2);
        ack(16'h0000);
        chk("t3_req_drop", 32'(mem_req), 32'd0);
        release_bus();
        tick(2);

        // Withheld ack: timeout after 24 cycles of mem_req
        cart_address = 23'h000200; cart_cs = 1; cart_oe = 1;
        wait_req();
        n = 1;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (mem_req) n++;
            else break;
        end
        chk("t4_req_len", 32'(n), 32'd24);
        chk("t4_late", 32'(late_err), 32'd1);
        chk("t4_en", 32'(cart_data_en), 32'd1);
        chk("t4_data", 32'(cart_data), 32'hFFFF);
        tick(2);
        ack(16'h1234);
        chk("t4_stray", 32'(cart_data), 32'hFFFF);
        chk("t4_stray_req", 32'(mem_req), 32'd0);
        release_bus();
        tick(2);

        // Reader lets go mid-request; request completes and fills cache
        cart_address = 23'h000300; cart_cs = 1; cart_oe = 1;
        wait_req();
        tick(1);
        release_bus();
        tick(3);
        chk("t5_req_held", 32'(mem_req), 32'd1);
        ack(16'hBEEF);
        chk("t5_req_drop", 32'(mem_req), 32'd0);
        chk("t5_no_en", 32'(cart_data_en), 32'd0);
        tick(2);
        cart_address = 23'h000300; cart_cs = 1; cart_oe = 1;
        tick(1);
        chk("t5_hit_en", 32'(cart_data_en), 32'd1);
        chk("t5_hit_data", 32'(cart_data), 32'hBEEF);
        release_bus();
        tick(2);

        // Asynchronous reset in the middle of a read request
        cart_address = 23'h000400; cart_cs = 1; cart_oe = 1;
        wait_req();
        tick(1);
        #1;
        SRES = 1'b0;
        #1;
        chk("t6_req", 32'(mem_req), 32'd0);
        chk("t6_en", 32'(cart_data_en), 32'd0);
        chk("t6_sram", 32'(sram_en), 32'd0);
        chk("t6_late", 32'(late_err), 32'd0);
        release_bus();
        tick(2);
        SRES = 1'b1;
        tick(2);
        cart_address = 23'h000300; cart_cs = 1; cart_oe = 1;
        wait_req();
        chk("t6_miss_addr", 32'(mem_addr), 32'h000300);
        tick(1);
        ack(16'h5555);
        chk("t6_data", 32'(cart_data), 32'h5555);
        release_bus();
        tick(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
